// File: rtl/eth_frame_builder.sv
// rtl/eth_frame_builder.sv - builds one Ethernet II / IPv4 / UDP frame into the transmit BRAM
//
// Purpose: computes the IPv4 header checksum for the current ident, writes the
// 42 header bytes, then copies the UDP payload stream into the buffer. It then
// requests transmission and holds off refilling until the transmitter is done.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_valid, s_data, s_ready    payload byte stream (accepted only in PAYLOAD)
//   bram_wr_en/addr/data        registered BRAM write port, byte i -> address i
//   tx_start, tx_busy           transmit request / transmitter busy handshake
//   busy                        builder is not idle

module eth_frame_builder #(
  parameter int          FRAME_LEN = 526,
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h020000000001,
  parameter logic [31:0] SRC_IP    = 32'hC0A80164,
  parameter logic [31:0] DST_IP    = 32'hFFFFFFFF,
  parameter logic [15:0] SRC_PORT  = 16'd1234,
  parameter logic [15:0] DST_PORT  = 16'd5678,
  parameter logic [7:0]  TTL       = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       bram_wr_en,
  output logic [9:0] bram_wr_addr,
  output logic [7:0] bram_wr_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  localparam logic [15:0] TOTAL_LEN = 16'(FRAME_LEN - 14);
  localparam logic [15:0] UDP_LEN   = 16'(FRAME_LEN - 34);
  localparam logic [9:0]  LAST_ADDR = 10'(FRAME_LEN - 1);
  localparam logic [9:0]  PAY_START = 10'd42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDR,
    S_PAYLOAD,
    S_REQ,
    S_DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;        // checksum word index in CSUM, header byte index in HDR
  logic [9:0]  pay_addr;   // next payload address
  logic [15:0] ident;
  logic [31:0] csum_acc;
  logic [15:0] csum_word;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] csum;
  logic        accept;
  logic [335:0] hdr_vec;
  logic [8:0]  hdr_lsb;
  logic [7:0]  hdr_byte;

  assign accept = s_valid && s_ready;

  // The accumulator is complete once HDR is entered, so the folded checksum
  // is stable for the whole header write.
  assign fold1 = {1'b0, csum_acc[15:0]} + {1'b0, csum_acc[31:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign csum  = ~fold2;

  assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, TOTAL_LEN, ident, 16'h4000, TTL, 8'h11, csum,
                    SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  // Byte 0 is the most significant byte of hdr_vec.
  assign hdr_lsb  = {3'b000, 6'd41 - cnt} << 3;
  assign hdr_byte = (cnt <= 6'd41) ? hdr_vec[hdr_lsb +: 8] : 8'h00;

  always_comb begin
    case (cnt)
      6'd0:    csum_word = 16'h4500;
      6'd1:    csum_word = TOTAL_LEN;
      6'd2:    csum_word = ident;
      6'd3:    csum_word = 16'h4000;
      6'd4:    csum_word = {TTL, 8'h11};
      6'd5:    csum_word = 16'h0000;
      6'd6:    csum_word = SRC_IP[31:16];
      6'd7:    csum_word = SRC_IP[15:0];
      6'd8:    csum_word = DST_IP[31:16];
      6'd9:    csum_word = DST_IP[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (s_valid)                         state_nx = S_CSUM;
      S_CSUM:    if (cnt == 6'd9)                     state_nx = S_HDR;
      S_HDR:     if (cnt == 6'd41)                    state_nx = S_PAYLOAD;
      S_PAYLOAD: if (accept && pay_addr == LAST_ADDR) state_nx = S_REQ;
      // tx_start stays up until the transmitter acknowledges with busy,
      // since it only samples start on its own clock enable.
      S_REQ:     if (tx_busy)                         state_nx = S_DRAIN;
      S_DRAIN:   if (!tx_busy)                        state_nx = S_IDLE;
      default:                                        state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready  = (state == S_PAYLOAD);
    tx_start = (state == S_REQ);
    busy     = (state != S_IDLE);
  end

  // Datapath and registered BRAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 6'd0;
      pay_addr     <= 10'd0;
      ident        <= 16'd0;
      csum_acc     <= 32'd0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= 10'd0;
      bram_wr_data <= 8'd0;
    end else begin
      bram_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= 6'd0;
          csum_acc <= 32'd0;
        end
        S_CSUM: begin
          csum_acc <= csum_acc + {16'd0, csum_word};
          cnt      <= (cnt == 6'd9) ? 6'd0 : cnt + 6'd1;
        end
        S_HDR: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= {4'd0, cnt};
          bram_wr_data <= hdr_byte;
          cnt          <= cnt + 6'd1;
          pay_addr     <= PAY_START;
        end
        S_PAYLOAD: begin
          if (accept) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= pay_addr;
            bram_wr_data <= s_data;
            pay_addr     <= pay_addr + 10'd1;
          end
        end
        S_DRAIN: begin
          if (!tx_busy) ident <= ident + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// tb/tb_eth_frame_builder.sv - directed self-checking bench for eth_frame_builder

module tb_eth_frame_builder;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       bram_wr_en;
  logic [9:0] bram_wr_addr;
  logic [7:0] bram_wr_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  int         exp_addr;
  int         wcount;
  logic       acc_q;

  eth_frame_builder dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  // Inspects the write port on the falling edge, then moves to just after
  // the next rising edge where stimulus is driven and outputs are sampled.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      acc_q = 1'b0;
    end else begin
      if (acc_q) chk("write_after_accept", exp_addr, 32'(bram_wr_en), 32'd1);
      if (bram_wr_en) begin
        chk("wr_addr_order", wcount, 32'(bram_wr_addr), 32'(exp_addr));
        chk("wr_addr_range", wcount, 32'(bram_wr_addr <= 10'd525), 32'd1);
        if (exp_addr >= 42) chk("write_without_accept", exp_addr, 32'(acc_q), 32'd1);
        mem[bram_wr_addr] = bram_wr_data;
        exp_addr++;
        wcount++;
      end
      acc_q = s_valid && s_ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit gaps, input bit early_busy, input int abort_at);
    int k;
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hxx;
    exp_addr = 0;
    wcount   = 0;
    k        = 0;
    cyc      = 0;
    s_valid  = 1'b1;
    s_data   = 8'h00;
    while (k < 484 && cyc < 3000) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst     = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("rst_wr_en",   k, 32'(bram_wr_en),   32'd0);
        chk("rst_wr_addr", k, 32'(bram_wr_addr), 32'd0);
        chk("rst_wr_data", k, 32'(bram_wr_data), 32'd0);
        chk("rst_s_ready", k, 32'(s_ready),      32'd0);
        chk("rst_tx_start",k, 32'(tx_start),     32'd0);
        chk("rst_busy",    k, 32'(busy),         32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", k, 32'(busy), 32'd0);
        return;
      end
      s_valid = (!gaps || !s_ready) ? 1'b1 : 1'($urandom_range(0, 1));
      s_data  = k[7:0];
      if (s_valid && s_ready) k++;
      if (early_busy && k == 484) tx_busy = 1'b1;
      step();
      cyc++;
    end
    chk("payload_accepted", cyc, 32'(k), 32'd484);

    // Keep offering data after the last byte; it must be held off.
    s_valid = 1'b1;
    chk("req_tx_start", 0, 32'(tx_start), 32'd1);
    chk("req_s_ready",  0, 32'(s_ready),  32'd0);
    if (early_busy) begin
      step();
      chk("early_busy_pulse", 0, 32'(tx_start), 32'd0);
      for (int i = 0; i < 9; i++) begin
        step();
        chk("early_drain_s_ready", i, 32'(s_ready), 32'd0);
        chk("early_drain_busy",    i, 32'(busy),    32'd1);
      end
    end else begin
      for (int i = 1; i < 20; i++) begin
        step();
        chk("req_hold_tx_start", i, 32'(tx_start), 32'd1);
        chk("req_hold_s_ready",  i, 32'(s_ready),  32'd0);
      end
      tx_busy = 1'b1;
      step();
      chk("drain_tx_start", 0, 32'(tx_start), 32'd0);
      for (int i = 0; i < 999; i++) begin
        step();
        chk("drain_tx_start", i, 32'(tx_start), 32'd0);
        chk("drain_s_ready",  i, 32'(s_ready),  32'd0);
        chk("drain_busy",     i, 32'(busy),     32'd1);
      end
    end
    tx_busy = 1'b0;
    step();
    chk("idle_after_drain", 0, 32'(busy), 32'd0);
    s_valid = 1'b0;
    step();
    chk("idle_stays", 0, 32'(busy), 32'd0);
    chk("write_count", 0, 32'(wcount), 32'd526);
  endtask

  task automatic check_frame(input logic [15:0] id, input logic [15:0] cs);
    logic [7:0] h [42];
    logic [7:0] p;
    h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
          8'h08, 8'h00,
          8'h45, 8'h00, 8'h02, 8'h00, id[15:8], id[7:0], 8'h40, 8'h00,
          8'h40, 8'h11, cs[15:8], cs[7:0],
          8'hC0, 8'hA8, 8'h01, 8'h64, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h04, 8'hD2, 8'h16, 8'h2E, 8'h01, 8'hEC, 8'h00, 8'h00};
    for (int i = 0; i < 42; i++) chk("hdr_byte", i, 32'(mem[i]), 32'(h[i]));
    for (int i = 42; i < 526; i++) begin
      p = 8'(i - 42);
      chk("payload_byte", i, 32'(mem[i]), 32'(p));
    end
    chk("last_byte", 525, 32'(mem[525]), 32'h0000_00E3);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    tx_busy = 1'b0;
    acc_q   = 1'b0;
    exp_addr = 0;
    wcount   = 0;
    #1;
    chk("reset_wr_en",    0, 32'(bram_wr_en),   32'd0);
    chk("reset_wr_addr",  0, 32'(bram_wr_addr), 32'd0);
    chk("reset_wr_data",  0, 32'(bram_wr_data), 32'd0);
    chk("reset_s_ready",  0, 32'(s_ready),      32'd0);
    chk("reset_tx_start", 0, 32'(tx_start),     32'd0);
    chk("reset_busy",     0, 32'(busy),         32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 0, 32'(busy), 32'd0);

    // Frame 1: gap-free, ident 0
    run_frame(1'b0, 1'b0, -1);
    check_frame(16'h0000, 16'h76E1);

    // Frame 2: random gaps, transmitter already busy on REQ, ident 1
    run_frame(1'b1, 1'b1, -1);
    check_frame(16'h0001, 16'h76E0);

    // Frame 3: reset mid-payload, then a clean frame from ident 0
    run_frame(1'b0, 1'b0, 100);
    run_frame(1'b0, 1'b1, -1);
    check_frame(16'h0000, 16'h76E1);

    // Ident wrap
    force dut.ident = 16'hFFFF;
    step();
    release dut.ident;
    run_frame(1'b0, 1'b1, -1);
    check_frame(16'hFFFF, 16'h76E1);
    run_frame(1'b0, 1'b1, -1);
    check_frame(16'h0000, 16'h76E1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
